register_bank_multiport: RTL and testbench

//  Parametrised general-purpose register bank for the ARMLEG datapath; successor to the fixed 32x64, 2-read/1-write file.

---
 rtl/armleg_pkg.sv | 15 +
 rtl/regbank_clear_seq.sv | 58 +++++
 rtl/register_bank_multiport.sv | 85 ++++++++
 tb/tb_register_bank_multiport.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/armleg_pkg.sv
// Shared constants and types for the ARMLEG general-purpose register bank.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package armleg_pkg;

  localparam int XZR_IDX    = 31;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regbank_clear_seq.sv
// Post-reset clear sequencer: sweeps every register index once, then grants access.
// Latency: DEPTH cycles from reset release to ready.
// Backpressure: none; the bank ignores external writes and returns zero until ready.
module regbank_clear_seq
  import armleg_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers; reset always restarts the sweep at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one index cleared per cycle, leave CLEAR after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/register_bank_multiport.sv
// Multi-read, single-write register bank with hardwired zero register and write-to-read forwarding.
// Latency: 1 cycle read (registered per port), writes visible to reads on the same edge via forwarding.
// Backpressure: none; accesses are ignored (reads return 0) while ready is low during the clear sweep.
module register_bank_multiport
  import armleg_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = XZR_IDX
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] readAddress,
  input  logic [NUM_RD-1:0]        readEnable,
  output logic [NUM_RD*DATA_W-1:0] regData,
  input  logic [ADDR_W-1:0]        writeAddress,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     regWrite,
  output logic                     ready
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              ext_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem [DEPTH];

  regbank_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (CLOCK),
    .rst      (RESET),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Write port mux: the clear sweep owns the port until ready; zero-register writes are dropped.
  always_comb begin
    ext_wr  = ready & ~RESET & regWrite & (writeAddress != ZERO_ADDR);
    wr_en   = clr_en | ext_wr;
    wr_addr = clr_en ? clr_addr : writeAddress;
    wr_data = clr_en ? '0 : writeData;
  end

  // Storage array; contents are only initialised by the sweep, never by reset directly.
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_q;

    assign ra = readAddress[p*ADDR_W +: ADDR_W];

    // Registered read: zero register first, then same-edge forwarding, else array contents.
    always_ff @(posedge CLOCK) begin
      if (RESET || !ready) begin
        rd_q <= '0;
      end else if (readEnable[p]) begin
        if (ra == ZERO_ADDR) begin
          rd_q <= '0;
        end else if (regWrite && (writeAddress == ra)) begin
          rd_q <= writeData;
        end else begin
          rd_q <= mem[ra];
        end
      end
    end

    assign regData[p*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_register_bank_multiport.sv
module tb_register_bank_multiport;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Default instance: 64-bit, 2 read ports
  logic        rst;
  logic [9:0]  raddr;
  logic [1:0]  ren;
  logic [127:0] rdata;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        wen;
  logic        rdy;

  // Wide instance: 32-bit, 4 read ports
  logic        rst4;
  logic [19:0] raddr4;
  logic [3:0]  ren4;
  logic [127:0] rdata4;
  logic [4:0]  waddr4;
  logic [31:0] wdata4;
  logic        wen4;
  logic        rdy4;

  always #5 clk = ~clk;

  register_bank_multiport dut (
    .CLOCK(clk), .RESET(rst), .readAddress(raddr), .readEnable(ren), .regData(rdata),
    .writeAddress(waddr), .writeData(wdata), .regWrite(wen), .ready(rdy)
  );

  register_bank_multiport #(.DATA_W(32), .NUM_RD(4)) dut4 (
    .CLOCK(clk), .RESET(rst4), .readAddress(raddr4), .readEnable(ren4), .regData(rdata4),
    .writeAddress(waddr4), .writeData(wdata4), .regWrite(wen4), .ready(rdy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises on the selected instance, bounded.
  task automatic cycles_to_ready(input bit wide, output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if ((wide ? rdy4 : rdy) == 1'b1) break;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; raddr = '0; ren = '0; waddr = '0; wdata = '0; wen = 1'b0;
    rst4 = 1'b1; raddr4 = '0; ren4 = '0; waddr4 = '0; wdata4 = '0; wen4 = 1'b0;

    // 1. reset state, sweep length, all registers zero
    tick();
    check("rst_ready", {63'd0, rdy}, 64'd0);
    check("rst_data", rdata[63:0] | rdata[127:64], 64'd0);
    rst = 1'b0;
    cycles_to_ready(1'b0, n);
    check("sweep_len", 64'(n), 64'd32);
    check("ready_up", {63'd0, rdy}, 64'd1);
    ren = 2'b11;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      tick();
      check("clr_p0", rdata[63:0], 64'd0);
      check("clr_p1", rdata[127:64], 64'd0);
    end
    ren = 2'b00;

    // 2. write r3 then read it
    wen = 1'b1; waddr = 5'd3; wdata = 64'h0000_0000_DEAD_BEEF;
    tick();
    wen = 1'b0; raddr = {5'd0, 5'd3}; ren = 2'b01;
    tick();
    check("r3_read", rdata[63:0], 64'h0000_0000_DEAD_BEEF);
    check("p1_hold", rdata[127:64], 64'd0);

    // 3. zero register ignores writes, including same-edge
    wen = 1'b1; waddr = 5'd31; wdata = 64'hFFFF_FFFF_FFFF_FFFF; ren = 2'b00;
    tick();
    raddr = {5'd31, 5'd31}; ren = 2'b11;
    tick();
    check("xzr_p0", rdata[63:0], 64'd0);
    check("xzr_p1", rdata[127:64], 64'd0);
    wen = 1'b0;

    // 4. same-edge forwarding
    wen = 1'b1; waddr = 5'd5; wdata = 64'h55; raddr = {5'd5, 5'd3}; ren = 2'b11;
    tick();
    check("fwd_p1", rdata[127:64], 64'h55);
    check("other_p0", rdata[63:0], 64'h0000_0000_DEAD_BEEF);
    wen = 1'b1; waddr = 5'd3; wdata = 64'h1234; raddr = {5'd7, 5'd3}; ren = 2'b01;
    tick();
    check("fwd_new", rdata[63:0], 64'h1234);
    check("hold_p1", rdata[127:64], 64'h55);
    wen = 1'b0; raddr = {5'd5, 5'd5}; ren = 2'b01;
    tick();
    check("r5_stored", rdata[63:0], 64'h55);

    // 5. reset mid-sweep; writes during CLEAR dropped
    wen = 1'b1; waddr = 5'd1; wdata = 64'h77; ren = 2'b00;
    tick();
    wen = 1'b0; raddr = {5'd0, 5'd1}; ren = 2'b01;
    tick();
    check("r1_pre", rdata[63:0], 64'h77);
    ren = 2'b00; rst = 1'b1;
    tick();
    check("rst2_data", rdata[63:0] | rdata[127:64], 64'd0);
    check("rst2_ready", {63'd0, rdy}, 64'd0);
    rst = 1'b0; wen = 1'b1; waddr = 5'd1; wdata = 64'hAA;
    repeat (10) tick();
    check("mid_ready", {63'd0, rdy}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cycles_to_ready(1'b0, n);
    check("resweep_len", 64'(n), 64'd32);
    wen = 1'b0; raddr = {5'd5, 5'd1}; ren = 2'b11;
    tick();
    check("r1_cleared", rdata[63:0], 64'd0);
    check("r5_cleared", rdata[127:64], 64'd0);

    // 6. four ports, 32-bit data
    tick();
    rst4 = 1'b0;
    cycles_to_ready(1'b1, n);
    check("w_sweep_len", 64'(n), 64'd32);
    wen4 = 1'b1; waddr4 = 5'd1; wdata4 = 32'd7;
    tick();
    waddr4 = 5'd2; wdata4 = 32'd9;
    tick();
    wen4 = 1'b0; raddr4 = {5'd31, 5'd1, 5'd2, 5'd1}; ren4 = 4'b1111;
    tick();
    check("w_p0", 64'(rdata4[31:0]), 64'd7);
    check("w_p1", 64'(rdata4[63:32]), 64'd9);
    check("w_p2", 64'(rdata4[95:64]), 64'd7);
    check("w_p3", 64'(rdata4[127:96]), 64'd0);
    raddr4 = {5'd2, 5'd2, 5'd2, 5'd2}; ren4 = 4'b1011;
    tick();
    check("w_p2_hold", 64'(rdata4[95:64]), 64'd7);
    check("w_p3_new", 64'(rdata4[127:96]), 64'd9);
    check("w_p0_new", 64'(rdata4[31:0]), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
